tapasco_dmi_initiator: RTL and testbench
========================================

TAPASCO_DMI_INITIATOR -- requirements
Module: tapasco_dmi_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum cycles spent in REQ+RESP before abort (range 1..65535).
REQ-002 SHALL have port clk_i  input  1  sole clock; all logic on the rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port host_req_i  input  1  level command strobe; the rising edge launches one transaction.
REQ-005 SHALL have port host_wr_i  input  1  1 = DMI write, 0 = DMI read; sampled on launch.
REQ-006 SHALL have port host_addr_i  input  7  DMI register address; sampled on launch.
REQ-007 SHALL have port host_wdata_i  input  32  write data; sampled on launch.
REQ-008 SHALL have port host_rdata_o  output  32  data of the last successful read; held.
REQ-009 SHALL have port host_busy_o  output  1  high while in REQ or RESP.
REQ-010 SHALL have port host_done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port host_err_o  output  1  status of the last transaction (1 = failed/busy/timeout); held.
REQ-012 SHALL have port host_ovr_o  output  1  sticky flag; a launch edge was ignored while busy.
REQ-013 SHALL have port dmi_req_valid_o  output  1  DMI request valid.
REQ-014 SHALL have port dmi_req_ready_i  input  1  DMI request ready from the debug module.
REQ-015 SHALL have port dmi_req_op_o  output  2  op: 0 NOP, 1 READ, 2 WRITE.
REQ-016 SHALL have port dmi_req_addr_o  output  7  request address.
REQ-017 SHALL have port dmi_req_data_o  output  32  request data.
REQ-018 SHALL have port dmi_resp_valid_i  input  1  DMI response valid.
REQ-019 SHALL have port dmi_resp_ready_o  output  1  DMI response ready.
REQ-020 SHALL have port dmi_resp_data_i  input  32  response data.
REQ-021 SHALL have port dmi_resp_resp_i  input  2  response code: 0 success, 2 failed, 3 busy.

Function
REQ-022 SHALL register host_req_i each cycle; launch = host_req_i high AND registered copy low.
REQ-023 SHALL implement FSM IDLE -> REQ -> RESP -> DONE -> IDLE.
REQ-024 IDLE: on launch, SHALL capture wr/addr/wdata into command registers, clear host_ovr_o, load the timeout counter with 0, and enter REQ next cycle.
REQ-025 REQ: dmi_req_valid_o=1; op = 2 if the captured wr=1, else 1; addr/data from command registers, stable until handshake; on valid&ready SHALL enter RESP.
REQ-026 RESP: dmi_resp_ready_o=1 (0 in all other states); on dmi_resp_valid_i SHALL enter DONE.
REQ-027 On response handshake: err := (resp != 0); if read AND resp == 0, host_rdata_o := dmi_resp_data_i; writes and errors SHALL leave host_rdata_o unchanged.
REQ-028 DONE: host_done_o=1 for exactly one cycle, then IDLE; the earliest next launch is accepted in IDLE.
REQ-029 Outside REQ, dmi_req_op_o SHALL be 0 (NOP) and dmi_req_valid_o 0.
REQ-030 Timeout counter SHALL increment every cycle in REQ or RESP; on reaching TIMEOUT_CYCLES without completing, the FSM SHALL go to DONE with err=1 and host_rdata_o unchanged; an abort from REQ drops valid without a handshake (deliberate).
REQ-031 A handshake in the same cycle that the count reaches TIMEOUT_CYCLES SHALL be treated as success: the handshake wins.
REQ-032 A launch edge in REQ, RESP or DONE SHALL be ignored and set host_ovr_o.
REQ-033 Minimum latency: launch at cycle N -> valid at N+1; with ready at N+1 and response at N+2, host_done_o at N+3.

Reset
REQ-034 While rst_ni=0 at a clock edge: FSM=IDLE, counter=0, host_rdata_o=0, host_err_o=0, host_ovr_o=0, host_done_o=0, dmi_req_valid_o=0, dmi_resp_ready_o=0, op=0, and the registered host_req_i copy=1 (prevents a launch on a level held through reset).
REQ-035 A reset asserted mid-transaction SHALL abandon the transaction with no done pulse.

Verification
REQ-036 Read: launch addr 0x11, ready immediate, response data 0xDEADBEEF resp 0 -> op=1, host_rdata_o=0xDEADBEEF, err=0, done at N+3.
REQ-037 Write: launch wr=1 addr 0x10 wdata 0x1; ready delayed 5 cycles -> op=2, data=0x1 stable while waiting; done pulse; rdata unchanged.
REQ-038 Error: read returns resp=2 data 0x5 -> err=1, rdata keeps its previous value.
REQ-039 Timeout: TIMEOUT_CYCLES=8, ready never asserted -> valid drops, done with err=1 eight cycles after valid first rose.
REQ-040 Overrun: toggle host_req_i low then high while in RESP -> ovr=1, no second request; the next launch clears ovr.
REQ-041 Reset: hold host_req_i=1 across rst_ni release -> no launch; assert reset in RESP -> outputs at reset values, no done pulse.

Source files
------------

// File: rtl/tapasco_dmi_initiator_if.sv
// Host command and DMI request/response signals of the TaPaSCo DMI initiator.
// The master modport is the initiator's view; the slave modport is the host/debug-module side.
interface tapasco_dmi_initiator_if;
  logic        host_req_i;
  logic        host_wr_i;
  logic [6:0]  host_addr_i;
  logic [31:0] host_wdata_i;
  logic [31:0] host_rdata_o;
  logic        host_busy_o;
  logic        host_done_o;
  logic        host_err_o;
  logic        host_ovr_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i;
  logic [1:0]  dmi_req_op_o;
  logic [6:0]  dmi_req_addr_o;
  logic [31:0] dmi_req_data_o;
  logic        dmi_resp_valid_i;
  logic        dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i;
  logic [1:0]  dmi_resp_resp_i;

  modport master (
    input  host_req_i, host_wr_i, host_addr_i, host_wdata_i,
           dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    output host_rdata_o, host_busy_o, host_done_o, host_err_o, host_ovr_o,
           dmi_req_valid_o, dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o,
           dmi_resp_ready_o
  );

  modport slave (
    output host_req_i, host_wr_i, host_addr_i, host_wdata_i,
           dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    input  host_rdata_o, host_busy_o, host_done_o, host_err_o, host_ovr_o,
           dmi_req_valid_o, dmi_req_op_o, dmi_req_addr_o, dmi_req_data_o,
           dmi_resp_ready_o
  );
endinterface

// File: rtl/tapasco_dmi_initiator.sv
// Turns a level host command strobe into one DMI read/write transaction with
// timeout abort, sticky overrun flag and held read data / error status.
module tapasco_dmi_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  tapasco_dmi_initiator_if.master        bus
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  OP_NOP   = 2'd0;
  localparam logic [1:0]  OP_READ  = 2'd1;
  localparam logic [1:0]  OP_WRITE = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_q;
  logic        req_q;
  logic        launch;
  logic        cmd_wr_q;
  logic [6:0]  cmd_addr_q;
  logic [31:0] cmd_wdata_q;
  logic [15:0] cnt_q;
  logic        cnt_last;
  logic [31:0] rdata_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        ovr_q;
  logic        valid_q;
  logic        resp_ready_q;
  logic [1:0]  op_q;

  assign launch = bus.host_req_i & ~req_q;
  // >= rather than == so a count that passed the limit in REQ still aborts RESP.
  assign cnt_last = (cnt_q >= CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_q        <= 1'b1;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      ovr_q        <= 1'b0;
      valid_q      <= 1'b0;
      resp_ready_q <= 1'b0;
      op_q         <= OP_NOP;
    end else begin
      req_q  <= bus.host_req_i;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch) begin
            cmd_wr_q    <= bus.host_wr_i;
            cmd_addr_q  <= bus.host_addr_i;
            cmd_wdata_q <= bus.host_wdata_i;
            ovr_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= REQ;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            op_q        <= bus.host_wr_i ? OP_WRITE : OP_READ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 16'd1;
          if (launch) ovr_q <= 1'b1;
          if (bus.dmi_req_ready_i) begin
            state_q      <= RESP;
            valid_q      <= 1'b0;
            op_q         <= OP_NOP;
            resp_ready_q <= 1'b1;
          end else if (cnt_last) begin
            // Abort drops valid without a handshake.
            state_q <= DONE;
            valid_q <= 1'b0;
            op_q    <= OP_NOP;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        RESP: begin
          cnt_q <= cnt_q + 16'd1;
          if (launch) ovr_q <= 1'b1;
          if (bus.dmi_resp_valid_i) begin
            state_q      <= DONE;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            err_q        <= (bus.dmi_resp_resp_i != 2'd0);
            if (!cmd_wr_q && bus.dmi_resp_resp_i == 2'd0) rdata_q <= bus.dmi_resp_data_i;
          end else if (cnt_last) begin
            state_q      <= DONE;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b1;
            done_q       <= 1'b1;
          end
        end
        DONE: begin
          if (launch) ovr_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.host_rdata_o     = rdata_q;
  assign bus.host_busy_o      = busy_q;
  assign bus.host_done_o      = done_q;
  assign bus.host_err_o       = err_q;
  assign bus.host_ovr_o       = ovr_q;
  assign bus.dmi_req_valid_o  = valid_q;
  assign bus.dmi_req_op_o     = op_q;
  assign bus.dmi_req_addr_o   = cmd_addr_q;
  assign bus.dmi_req_data_o   = cmd_wdata_q;
  assign bus.dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_tapasco_dmi_initiator.sv
// Self-checking bench: table of DMI transactions with a queue scoreboard for
// err/rdata, plus hand-written reset, overrun and mid-transaction reset sequences.
module tb_tapasco_dmi_initiator;

  localparam int TO = 8;

  logic clk_i;
  logic rst_ni;

  tapasco_dmi_initiator_if ifc ();

  tapasco_dmi_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (ifc.master)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          ready_delay;
    int          resp_delay;
    logic [31:0] resp_data;
    logic [1:0]  resp_code;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  logic [31:0] model_rdata;
  int          checks;
  int          errors;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic check_reset_values();
    check_output("rst_valid", 32'(ifc.dmi_req_valid_o), 32'd0);
    check_output("rst_op", 32'(ifc.dmi_req_op_o), 32'd0);
    check_output("rst_resp_ready", 32'(ifc.dmi_resp_ready_o), 32'd0);
    check_output("rst_busy", 32'(ifc.host_busy_o), 32'd0);
    check_output("rst_done", 32'(ifc.host_done_o), 32'd0);
    check_output("rst_err", 32'(ifc.host_err_o), 32'd0);
    check_output("rst_ovr", 32'(ifc.host_ovr_o), 32'd0);
    check_output("rst_rdata", ifc.host_rdata_o, 32'd0);
  endtask

  task automatic pop_and_compare();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_empty: got done pulse want queued expectation");
    end else begin
      e = sb.pop_front();
      check_output("sb_err", 32'(ifc.host_err_o), 32'(e.err));
      check_output("sb_rdata", ifc.host_rdata_o, e.rdata);
    end
  endtask

  // Drives one transaction from the host side and plays the debug module.
  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    logic timeout;
    int   used;
    int   resp_cnt;
    logic timed_out;
    timeout = (v.ready_delay + 1 > TO) || (v.ready_delay + v.resp_delay + 2 > TO);
    e.err = timeout || (v.resp_code != 2'd0);
    if (!timeout && !v.wr && v.resp_code == 2'd0) model_rdata = v.resp_data;
    e.rdata = model_rdata;
    sb.push_back(e);

    @(negedge clk_i);
    ifc.host_wr_i    = v.wr;
    ifc.host_addr_i  = v.addr;
    ifc.host_wdata_i = v.wdata;
    ifc.host_req_i   = 1'b1;
    @(negedge clk_i);
    ifc.host_req_i   = 1'b0;
    check_output("launch_ovr_clear", 32'(ifc.host_ovr_o), 32'd0);

    used = 0;
    timed_out = 1'b0;
    while (1) begin
      check_output("req_valid", 32'(ifc.dmi_req_valid_o), 32'd1);
      check_output("req_op", 32'(ifc.dmi_req_op_o), v.wr ? 32'd2 : 32'd1);
      check_output("req_addr", 32'(ifc.dmi_req_addr_o), 32'(v.addr));
      check_output("req_data", ifc.dmi_req_data_o, v.wdata);
      check_output("req_busy", 32'(ifc.host_busy_o), 32'd1);
      check_output("req_done", 32'(ifc.host_done_o), 32'd0);
      used++;
      if (used - 1 == v.ready_delay) begin
        ifc.dmi_req_ready_i = 1'b1;
        @(negedge clk_i);
        ifc.dmi_req_ready_i = 1'b0;
        break;
      end
      @(negedge clk_i);
      if (used >= TO) begin
        timed_out = 1'b1;
        break;
      end
    end

    if (!timed_out) begin
      resp_cnt = 0;
      while (1) begin
        check_output("resp_ready", 32'(ifc.dmi_resp_ready_o), 32'd1);
        check_output("resp_valid_low", 32'(ifc.dmi_req_valid_o), 32'd0);
        check_output("resp_op_nop", 32'(ifc.dmi_req_op_o), 32'd0);
        used++;
        if (resp_cnt == v.resp_delay) begin
          ifc.dmi_resp_valid_i = 1'b1;
          ifc.dmi_resp_data_i  = v.resp_data;
          ifc.dmi_resp_resp_i  = v.resp_code;
          @(negedge clk_i);
          ifc.dmi_resp_valid_i = 1'b0;
          break;
        end
        resp_cnt++;
        @(negedge clk_i);
        if (used >= TO) break;
      end
    end

    check_output("done_pulse", 32'(ifc.host_done_o), 32'd1);
    check_output("done_busy", 32'(ifc.host_busy_o), 32'd0);
    check_output("done_valid", 32'(ifc.dmi_req_valid_o), 32'd0);
    check_output("done_resp_ready", 32'(ifc.dmi_resp_ready_o), 32'd0);
    pop_and_compare();
    @(negedge clk_i);
    check_output("done_one_cycle", 32'(ifc.host_done_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    model_rdata = 32'd0;
    //          wr    addr   wdata         rdy  rsp  resp_data     code
    vecs[0] = '{1'b0, 7'h11, 32'h0,         0,   0, 32'hDEADBEEF, 2'd0};
    vecs[1] = '{1'b1, 7'h10, 32'h1,         5,   0, 32'h0,        2'd0};
    vecs[2] = '{1'b0, 7'h12, 32'h0,         0,   0, 32'h5,        2'd2};
    vecs[3] = '{1'b0, 7'h13, 32'h0,         1,   1, 32'h77,       2'd3};
    vecs[4] = '{1'b0, 7'h7F, 32'h0,         3,   3, 32'h12345678, 2'd0};
    vecs[5] = '{1'b0, 7'h20, 32'h0,         3,   4, 32'h9999,     2'd0};
    vecs[6] = '{1'b1, 7'h21, 32'hABCD0123, 99,   0, 32'h0,        2'd0};

    rst_ni               = 1'b0;
    ifc.host_req_i       = 1'b1;
    ifc.host_wr_i        = 1'b0;
    ifc.host_addr_i      = 7'h0;
    ifc.host_wdata_i     = 32'h0;
    ifc.dmi_req_ready_i  = 1'b0;
    ifc.dmi_resp_valid_i = 1'b0;
    ifc.dmi_resp_data_i  = 32'h0;
    ifc.dmi_resp_resp_i  = 2'd0;

    repeat (3) @(negedge clk_i);
    check_reset_values();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_output("held_req_no_launch", 32'(ifc.dmi_req_valid_o), 32'd0);
      check_output("held_req_not_busy", 32'(ifc.host_busy_o), 32'd0);
    end
    ifc.host_req_i = 1'b0;

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

    // Overrun: re-launch while waiting for the response.
    sb.push_back('{1'b0, 32'hCAFE0001});
    model_rdata = 32'hCAFE0001;
    @(negedge clk_i);
    ifc.host_wr_i   = 1'b0;
    ifc.host_addr_i = 7'h30;
    ifc.host_req_i  = 1'b1;
    @(negedge clk_i);
    ifc.host_req_i      = 1'b0;
    ifc.dmi_req_ready_i = 1'b1;
    @(negedge clk_i);
    ifc.dmi_req_ready_i = 1'b0;
    ifc.host_req_i      = 1'b1;
    @(negedge clk_i);
    check_output("ovr_set", 32'(ifc.host_ovr_o), 32'd1);
    check_output("ovr_still_resp", 32'(ifc.dmi_resp_ready_o), 32'd1);
    ifc.host_req_i = 1'b0;
    @(negedge clk_i);
    check_output("ovr_no_second_req", 32'(ifc.dmi_req_valid_o), 32'd0);
    ifc.dmi_resp_valid_i = 1'b1;
    ifc.dmi_resp_data_i  = 32'hCAFE0001;
    ifc.dmi_resp_resp_i  = 2'd0;
    @(negedge clk_i);
    ifc.dmi_resp_valid_i = 1'b0;
    check_output("ovr_done", 32'(ifc.host_done_o), 32'd1);
    pop_and_compare();
    @(negedge clk_i);
    check_output("ovr_sticky", 32'(ifc.host_ovr_o), 32'd1);
    check_output("ovr_idle_valid", 32'(ifc.dmi_req_valid_o), 32'd0);
    apply_stimulus('{1'b1, 7'h31, 32'h55, 0, 0, 32'h0, 2'd0});

    // Reset while in RESP abandons the transaction.
    @(negedge clk_i);
    ifc.host_wr_i   = 1'b0;
    ifc.host_addr_i = 7'h22;
    ifc.host_req_i  = 1'b1;
    @(negedge clk_i);
    ifc.host_req_i      = 1'b0;
    ifc.dmi_req_ready_i = 1'b1;
    @(negedge clk_i);
    ifc.dmi_req_ready_i = 1'b0;
    check_output("midrst_in_resp", 32'(ifc.dmi_resp_ready_o), 32'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_reset_values();
    rst_ni = 1'b1;
    model_rdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_output("midrst_no_done", 32'(ifc.host_done_o), 32'd0);
      check_output("midrst_idle", 32'(ifc.dmi_req_valid_o), 32'd0);
    end
    apply_stimulus('{1'b0, 7'h05, 32'h0, 0, 0, 32'hA5A5A5A5, 2'd0});

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_leftover: got %0d entries want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
